answer_checker: RTL and testbench

ANSWER_CHECKER -- requirements
Module: answer_checker

---
 rtl/answer_checker.sv | 264 ++++++++++++++++++++++++++
 tb/tb_answer_checker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/answer_checker.sv
`default_nettype none
// ============================================================================
// Module      : answer_checker
// Description : Checks a player's three-step arithmetic solution to a
//               "make 24" puzzle. Four 16-bit signed slots are loaded from
//               the puzzle numbers. Each accepted step combines two live
//               slots. The result replaces slot src_a and slot src_b is
//               retired. Division runs on a 16-cycle restoring divider and
//               must be exact. After three good steps the final value is
//               compared against 24.
// Ports       : clk, rst_n            - clock, async active-low reset
//               load, num1..num4      - start a round with four numbers
//               step_valid, src_a,
//               src_b, op             - one operation step (add/sub/mul/div)
//               step_ready            - step can be accepted this cycle
//               busy                  - EXEC, DIV or CHECK in progress
//               done, win, err        - round outcome, held until load
//               result                - last value written to a slot
// Revision    : 1.0  initial release
// ============================================================================
module answer_checker (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [3:0]  num1,
    input  logic [3:0]  num2,
    input  logic [3:0]  num3,
    input  logic [3:0]  num4,
    input  logic        step_valid,
    input  logic [1:0]  src_a,
    input  logic [1:0]  src_b,
    input  logic [1:0]  op,
    output logic        step_ready,
    output logic        busy,
    output logic        done,
    output logic        win,
    output logic [1:0]  err,
    output logic [15:0] result
);

    localparam logic [1:0] C_OP_ADD = 2'b00;
    localparam logic [1:0] C_OP_SUB = 2'b01;
    localparam logic [1:0] C_OP_MUL = 2'b10;
    localparam logic [1:0] C_OP_DIV = 2'b11;

    localparam logic [1:0] C_ERR_NONE    = 2'b00;
    localparam logic [1:0] C_ERR_SLOT    = 2'b01;
    localparam logic [1:0] C_ERR_DIVZERO = 2'b10;
    localparam logic [1:0] C_ERR_INEXACT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_STEP = 3'd1,
        S_EXEC      = 3'd2,
        S_DIV       = 3'd3,
        S_CHECK     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [3:0][15:0]  slot_q, slot_d;
    logic [3:0]        used_q, used_d;
    logic [1:0]        step_cnt_q, step_cnt_d;
    logic [15:0]       result_q, result_d;
    logic              win_q, win_d;
    logic [1:0]        err_q, err_d;
    logic [1:0]        a_idx_q, a_idx_d;
    logic [1:0]        b_idx_q, b_idx_d;
    logic [1:0]        op_q, op_d;
    // Divider: quo_q starts as the dividend magnitude and shifts left while
    // quotient bits enter at the LSB; rem_q is the partial remainder.
    logic [15:0]       rem_q, rem_d;
    logic [15:0]       quo_q, quo_d;
    logic [15:0]       dvs_q, dvs_d;
    logic              neg_q, neg_d;
    logic [3:0]        div_cnt_q, div_cnt_d;

    logic [15:0]       w_in_a, w_in_b;
    logic [15:0]       w_mag_a, w_mag_b;
    logic signed [15:0] w_sa, w_sb, w_alu;
    logic [16:0]       w_rem_sh;
    logic              w_ge;
    logic [15:0]       w_rem_nxt, w_quo_nxt, w_quo_fin;
    logic              w_commit;
    logic [15:0]       w_commit_val;

    // Operand magnitudes for a division about to be accepted.
    assign w_in_a  = slot_q[src_a];
    assign w_in_b  = slot_q[src_b];
    assign w_mag_a = w_in_a[15] ? (16'd0 - w_in_a) : w_in_a;
    assign w_mag_b = w_in_b[15] ? (16'd0 - w_in_b) : w_in_b;

    // ALU operands for the step captured at acceptance.
    assign w_sa = $signed(slot_q[a_idx_q]);
    assign w_sb = $signed(slot_q[b_idx_q]);

    always_comb begin
        w_alu = '0;
        case (op_q)
            C_OP_ADD: w_alu = w_sa + w_sb;
            C_OP_SUB: w_alu = w_sa - w_sb;
            C_OP_MUL: w_alu = w_sa * w_sb;
            default:  w_alu = '0;
        endcase
    end

    // One restoring-division iteration.
    assign w_rem_sh  = {rem_q, quo_q[15]};
    assign w_ge      = (w_rem_sh >= {1'b0, dvs_q});
    assign w_rem_nxt = w_ge ? 16'(w_rem_sh - {1'b0, dvs_q}) : w_rem_sh[15:0];
    assign w_quo_nxt = {quo_q[14:0], w_ge};
    assign w_quo_fin = neg_q ? (16'd0 - w_quo_nxt) : w_quo_nxt;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        used_d       = used_q;
        step_cnt_d   = step_cnt_q;
        result_d     = result_q;
        win_d        = win_q;
        err_d        = err_q;
        a_idx_d      = a_idx_q;
        b_idx_d      = b_idx_q;
        op_d         = op_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvs_d        = dvs_q;
        neg_d        = neg_q;
        div_cnt_d    = div_cnt_q;
        w_commit     = 1'b0;
        w_commit_val = '0;

        if (load) begin
            // A new puzzle aborts whatever was in progress.
            state_d    = S_WAIT_STEP;
            slot_d[0]  = {12'd0, num1};
            slot_d[1]  = {12'd0, num2};
            slot_d[2]  = {12'd0, num3};
            slot_d[3]  = {12'd0, num4};
            used_d     = '0;
            step_cnt_d = '0;
            win_d      = 1'b0;
            err_d      = C_ERR_NONE;
            div_cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_WAIT_STEP: begin
                    if (step_valid) begin
                        a_idx_d = src_a;
                        b_idx_d = src_b;
                        op_d    = op;
                        if ((src_a == src_b) || used_q[src_a] || used_q[src_b]) begin
                            state_d = S_DONE;
                            err_d   = C_ERR_SLOT;
                            win_d   = 1'b0;
                        end else if (op == C_OP_DIV) begin
                            if (w_in_b == 16'd0) begin
                                state_d = S_DONE;
                                err_d   = C_ERR_DIVZERO;
                                win_d   = 1'b0;
                            end else begin
                                state_d   = S_DIV;
                                rem_d     = '0;
                                quo_d     = w_mag_a;
                                dvs_d     = w_mag_b;
                                neg_d     = w_in_a[15] ^ w_in_b[15];
                                div_cnt_d = '0;
                            end
                        end else begin
                            state_d = S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    w_commit     = 1'b1;
                    w_commit_val = w_alu;
                end
                S_DIV: begin
                    rem_d     = w_rem_nxt;
                    quo_d     = w_quo_nxt;
                    div_cnt_d = div_cnt_q + 4'd1;
                    if (div_cnt_q == 4'd15) begin
                        if (w_rem_nxt != 16'd0) begin
                            state_d = S_DONE;
                            err_d   = C_ERR_INEXACT;
                            win_d   = 1'b0;
                        end else begin
                            w_commit     = 1'b1;
                            w_commit_val = w_quo_fin;
                        end
                    end
                end
                S_CHECK: begin
                    state_d = S_DONE;
                    win_d   = (result_q == 16'd24);
                    err_d   = C_ERR_NONE;
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Shared write-back for EXEC and a successful DIV exit.
            if (w_commit) begin
                slot_d[a_idx_q]  = w_commit_val;
                result_d         = w_commit_val;
                used_d[b_idx_q]  = 1'b1;
                step_cnt_d       = step_cnt_q + 2'd1;
                state_d          = (step_cnt_q == 2'd2) ? S_CHECK : S_WAIT_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            slot_q     <= '0;
            used_q     <= '0;
            step_cnt_q <= '0;
            result_q   <= '0;
            win_q      <= 1'b0;
            err_q      <= C_ERR_NONE;
            a_idx_q    <= '0;
            b_idx_q    <= '0;
            op_q       <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_q      <= 1'b0;
            div_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            used_q     <= used_d;
            step_cnt_q <= step_cnt_d;
            result_q   <= result_d;
            win_q      <= win_d;
            err_q      <= err_d;
            a_idx_q    <= a_idx_d;
            b_idx_q    <= b_idx_d;
            op_q       <= op_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            neg_q      <= neg_d;
            div_cnt_q  <= div_cnt_d;
        end
    end

    assign step_ready = (state_q == S_WAIT_STEP);
    assign busy       = (state_q == S_EXEC) || (state_q == S_DIV) || (state_q == S_CHECK);
    assign done       = (state_q == S_DONE);
    assign win        = win_q;
    assign err        = err_q;
    assign result     = result_q;

endmodule
`default_nettype wire

// File: tb/tb_answer_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_answer_checker
// Description : Directed and random stimulus for answer_checker, checked
//               against a slot-array reference model using plain integer
//               arithmetic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_answer_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [3:0]  num1 = '0, num2 = '0, num3 = '0, num4 = '0;
    logic        step_valid = 1'b0;
    logic [1:0]  src_a = '0, src_b = '0, op = '0;
    logic        step_ready, busy, done, win;
    logic [1:0]  err;
    logic [15:0] result;

    answer_checker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .num1       (num1),
        .num2       (num2),
        .num3       (num3),
        .num4       (num4),
        .step_valid (step_valid),
        .src_a      (src_a),
        .src_b      (src_b),
        .op         (op),
        .step_ready (step_ready),
        .busy       (busy),
        .done       (done),
        .win        (win),
        .err        (err),
        .result     (result)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model of the puzzle state.
    int m_slot [4];
    bit m_used [4];
    int m_cnt;
    int m_res;
    int m_err;
    bit m_win;
    bit m_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic [31:0] sres();
        return {{16{result[15]}}, result};
    endfunction

    task automatic do_load(input int n1, input int n2, input int n3, input int n4);
        load = 1'b1;
        num1 = 4'(n1); num2 = 4'(n2); num3 = 4'(n3); num4 = 4'(n4);
        tick();
        load = 1'b0;
        m_slot[0] = n1; m_slot[1] = n2; m_slot[2] = n3; m_slot[3] = n4;
        for (int i = 0; i < 4; i++) m_used[i] = 1'b0;
        m_cnt = 0; m_err = 0; m_win = 1'b0; m_done = 1'b0;
        chk("load_ready", 32'(step_ready), 32'd1);
        chk("load_done",  32'(done),       32'd0);
        chk("load_busy",  32'(busy),       32'd0);
        chk("load_err",   32'(err),        32'd0);
        chk("load_win",   32'(win),        32'd0);
    endtask

    task automatic do_step(input int a, input int b, input int o);
        int ea, eb, val, exp_n, n, nb;
        ea = m_slot[a];
        eb = m_slot[b];
        val = 0;
        if (a == b || m_used[a] || m_used[b]) m_err = 1;
        else if (o == 3 && eb == 0)           m_err = 2;
        else if (o == 3 && (ea % eb) != 0)    m_err = 3;
        else                                  m_err = 0;
        if (m_err == 0) begin
            case (o)
                0: val = ea + eb;
                1: val = ea - eb;
                2: val = ea * eb;
                default: val = ea / eb;
            endcase
            m_slot[a] = val;
            m_used[b] = 1'b1;
            m_cnt++;
            m_res = val;
        end
        if (m_err == 1 || m_err == 2) exp_n = 0;
        else if (m_err == 3)          exp_n = 16;
        else                          exp_n = ((o == 3) ? 16 : 1) + ((m_cnt == 3) ? 1 : 0);
        m_done = (m_err != 0) || (m_cnt == 3);
        m_win  = (m_err == 0) && (m_cnt == 3) && (val == 24);

        chk("step_ready_before", 32'(step_ready), 32'd1);
        step_valid = 1'b1;
        src_a = 2'(a); src_b = 2'(b); op = 2'(o);
        tick();
        step_valid = 1'b0;
        n = 0; nb = 0;
        while (!(step_ready || done) && n < 60) begin
            if (busy) nb++;
            tick();
            n++;
        end
        chk("step_latency", 32'(n),          32'(exp_n));
        chk("step_busy",    32'(nb),         32'(exp_n));
        chk("step_done",    32'(done),       32'(m_done));
        chk("step_ready",   32'(step_ready), 32'(!m_done));
        chk("step_err",     32'(err),        32'(m_err));
        chk("step_win",     32'(win),        32'(m_win));
        chk("step_result",  sres(),          32'(m_res));
    endtask

    task automatic done_hold();
        step_valid = 1'b1;
        src_a = 2'($urandom_range(0, 3)); src_b = 2'($urandom_range(0, 3));
        op = 2'($urandom_range(0, 3));
        tick();
        tick();
        step_valid = 1'b0;
        chk("hold_done",   32'(done),   32'd1);
        chk("hold_busy",   32'(busy),   32'd0);
        chk("hold_err",    32'(err),    32'(m_err));
        chk("hold_win",    32'(win),    32'(m_win));
        chk("hold_result", sres(),      32'(m_res));
    endtask

    initial begin
        m_res = 0;
        // Reset state
        tick(); tick();
        chk("rst_ready",  32'(step_ready), 32'd0);
        chk("rst_busy",   32'(busy),       32'd0);
        chk("rst_done",   32'(done),       32'd0);
        chk("rst_result", sres(),          32'd0);
        rst_n = 1'b1;
        // Steps offered in IDLE are ignored
        step_valid = 1'b1;
        tick(); tick(); tick();
        step_valid = 1'b0;
        chk("idle_ready", 32'(step_ready), 32'd0);
        chk("idle_busy",  32'(busy),       32'd0);
        chk("idle_done",  32'(done),       32'd0);

        // 2,4,8,11: (11-8)=3, 2*3=6, 6*4=24
        do_load(2, 4, 8, 11);
        do_step(3, 2, 1);
        do_step(0, 3, 2);
        do_step(0, 1, 2);
        done_hold();

        // 4,4,9,12: 12/4=3, 9-3=6, 6*4=24
        do_load(4, 4, 9, 12);
        do_step(3, 0, 3);
        do_step(2, 3, 1);
        do_step(2, 1, 2);

        // Inexact division 7/2
        do_load(7, 2, 1, 1);
        do_step(0, 1, 3);
        done_hold();

        // Divide by zero after 4-4=0
        do_load(4, 4, 9, 12);
        do_step(0, 1, 1);
        do_step(2, 0, 3);
        // Reusing a retired slot
        do_load(4, 4, 9, 12);
        do_step(0, 1, 1);
        do_step(1, 2, 0);
        // Same slot on both sides
        do_load(4, 4, 9, 12);
        do_step(2, 2, 0);

        // Asynchronous reset on DIV cycle 8
        do_load(4, 4, 9, 12);
        step_valid = 1'b1; src_a = 2'd3; src_b = 2'd0; op = 2'd3;
        tick();
        step_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("div8_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        m_res = 0;
        chk("arst_ready",  32'(step_ready), 32'd0);
        chk("arst_busy",   32'(busy),       32'd0);
        chk("arst_done",   32'(done),       32'd0);
        chk("arst_win",    32'(win),        32'd0);
        chk("arst_err",    32'(err),        32'd0);
        chk("arst_result", sres(),          32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_ready", 32'(step_ready), 32'd0);
        chk("post_rst_busy",  32'(busy),       32'd0);

        // Reload in the middle of a round
        do_load(2, 4, 8, 11);
        do_step(3, 2, 1);
        do_load(1, 3, 7, 12);
        do_step(2, 0, 0);
        do_step(1, 2, 2);
        do_step(1, 0, 2);

        // Random rounds
        for (int r = 0; r < 60; r++) begin
            do_load($urandom_range(1, 13), $urandom_range(1, 13),
                    $urandom_range(1, 13), $urandom_range(1, 13));
            for (int s = 0; s < 3 && !m_done; s++) begin
                int a, b;
                if ($urandom_range(0, 9) < 8) begin
                    do a = $urandom_range(0, 3); while (m_used[a]);
                    do b = $urandom_range(0, 3); while (m_used[b] || b == a);
                end else begin
                    a = $urandom_range(0, 3);
                    b = $urandom_range(0, 3);
                end
                do_step(a, b, $urandom_range(0, 3));
            end
            if (m_done && $urandom_range(0, 3) == 0) done_hold();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
